// File: rtl/arp_pkg.sv
// Shared ARP definitions: FSM encoding, ARP oper codes, broadcast MAC and
// the address classification helpers used by the request engine.
package arp_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    QUERY    = 3'd1,
    WAIT     = 3'd2,
    RESPOND  = 3'd3,
    ANNOUNCE = 3'd4
  } arp_state_e;

  localparam logic [15:0] ARP_OPER_REQUEST     = 16'h0001;
  localparam logic [15:0] ARP_OPER_REPLY       = 16'h0002;
  localparam logic [15:0] ARP_OPER_INV_REQUEST = 16'h0008;
  localparam logic [15:0] ARP_OPER_INV_REPLY   = 16'h0009;

  localparam logic [47:0] ARP_BCAST_MAC = 48'hFFFF_FFFF_FFFF;

  // All host bits set means a directed (or limited) broadcast address.
  function automatic logic arp_is_bcast(input logic [31:0] ip, input logic [31:0] mask);
    return (~(ip | mask)) == 32'h0000_0000;
  endfunction

  // Same network prefix as the gateway means the target is on-link.
  function automatic logic arp_on_subnet(input logic [31:0] ip, input logic [31:0] gw,
                                         input logic [31:0] mask);
    return ((ip ^ gw) & mask) == 32'h0000_0000;
  endfunction

endpackage

// File: rtl/arp_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or above ptr_i,
// wrapping around, as a one-hot vector plus its index.
module arp_rr_arbiter #(
  parameter int CLIENTS = 4,
  localparam int IDXW = (CLIENTS > 1) ? $clog2(CLIENTS) : 1
) (
  input  logic               en_i,
  input  logic [CLIENTS-1:0] req_i,
  input  logic [IDXW-1:0]    ptr_i,
  output logic [CLIENTS-1:0] gnt_o,
  output logic [IDXW-1:0]    idx_o
);

  logic            found_s;
  logic [IDXW:0]   sum_s;
  logic [IDXW-1:0] cand_s;

  // Scan all clients starting at the pointer and keep the first requester.
  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    found_s = 1'b0;
    sum_s   = '0;
    cand_s  = '0;
    for (int k = 0; k < CLIENTS; k++) begin
      sum_s  = {1'b0, ptr_i} + (IDXW+1)'(k);
      cand_s = (sum_s >= (IDXW+1)'(CLIENTS)) ? IDXW'(sum_s - (IDXW+1)'(CLIENTS))
                                             : sum_s[IDXW-1:0];
      if (en_i && !found_s && req_i[cand_s]) begin
        found_s        = 1'b1;
        gnt_o[cand_s]  = 1'b1;
        idx_o          = cand_s;
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/arp_req_engine.sv
// ARP request engine: arbitrates client lookups, classifies the address,
// queries the cache, sends request frames with retries and answers the client.
module arp_req_engine
  import arp_pkg::*;
#(
  parameter int              CLIENTS        = 4,
  parameter int              RETRY_COUNT    = 4,
  parameter longint unsigned RETRY_INTERVAL = 64'd250000000,
  parameter longint unsigned TIMEOUT        = 64'd3750000000,
  parameter int              TIMER_WIDTH    = 36
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [CLIENTS-1:0]    req_valid,
  output logic [CLIENTS-1:0]    req_ready,
  input  logic [CLIENTS*32-1:0] req_ip,
  output logic [CLIENTS-1:0]    resp_valid,
  input  logic [CLIENTS-1:0]    resp_ready,
  output logic                  resp_error,
  output logic [47:0]           resp_mac,
  output logic                  cache_query_valid,
  output logic [31:0]           cache_query_ip,
  input  logic                  cache_resp_valid,
  input  logic                  cache_resp_error,
  input  logic [47:0]           cache_resp_mac,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic [31:0]           tx_tpa,
  output logic                  tx_gratuitous,
  input  logic [31:0]           local_ip,
  input  logic [31:0]           gateway_ip,
  input  logic [31:0]           subnet_mask,
  input  logic                  announce,
  output logic                  busy
);

  localparam int IDXW = (CLIENTS > 1) ? $clog2(CLIENTS) : 1;
  localparam int RW   = $clog2(RETRY_COUNT + 1);
  localparam logic [TIMER_WIDTH-1:0] RI_C    = TIMER_WIDTH'(RETRY_INTERVAL);
  localparam logic [TIMER_WIDTH-1:0] TO_C    = TIMER_WIDTH'(TIMEOUT);
  localparam logic [TIMER_WIDTH-1:0] FIRST_C = (RETRY_COUNT == 1) ? TO_C : RI_C;
  localparam logic [RW-1:0]          RC_LOAD = RW'(RETRY_COUNT - 1);

  arp_state_e             state_q, state_d;
  logic [IDXW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [IDXW-1:0]        client_q, client_d;
  logic [31:0]            target_q, target_d;
  logic [47:0]            resp_mac_q, resp_mac_d;
  logic                   resp_err_q, resp_err_d;
  logic                   tx_valid_q, tx_valid_d;
  logic [31:0]            tx_tpa_q, tx_tpa_d;
  logic                   tx_grat_q, tx_grat_d;
  logic [RW-1:0]          retry_q, retry_d;
  logic [TIMER_WIDTH-1:0] timer_q, timer_d;
  logic                   pend_q, pend_d;
  logic                   run_q;

  logic [CLIENTS-1:0]     gnt_s;
  logic [IDXW-1:0]        gnt_idx_s;
  logic [31:0]            sel_ip_s;
  logic                   hit_s;
  logic                   arb_en_s;

  // Grants are only offered when idle, no announce is waiting and reset has released.
  assign arb_en_s = (state_q == IDLE) && !pend_q && run_q;
  assign hit_s    = cache_resp_valid && !cache_resp_error;

  arp_rr_arbiter #(.CLIENTS(CLIENTS)) u_arb (
    .en_i  (arb_en_s),
    .req_i (req_valid),
    .ptr_i (rr_ptr_q),
    .gnt_o (gnt_s),
    .idx_o (gnt_idx_s)
  );

  // Pick the IP of the granted client.
  always_comb begin
    sel_ip_s = 32'h0000_0000;
    for (int k = 0; k < CLIENTS; k++) begin
      if (gnt_s[k]) begin
        sel_ip_s = req_ip[32*k +: 32];
      end else begin
        sel_ip_s = sel_ip_s;
      end
    end
  end

  // Next-state logic for the lookup FSM, transmit slot, retry timer and announce flag.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    client_d   = client_q;
    target_d   = target_q;
    resp_mac_d = resp_mac_q;
    resp_err_d = resp_err_q;
    tx_tpa_d   = tx_tpa_q;
    tx_grat_d  = tx_grat_q;
    retry_d    = retry_q;
    timer_d    = timer_q;
    pend_d     = pend_q | announce;
    if (tx_valid_q && tx_ready) begin
      tx_valid_d = 1'b0;
    end else begin
      tx_valid_d = tx_valid_q;
    end
    case (state_q)
      IDLE: begin
        if (pend_q) begin
          state_d = ANNOUNCE;
        end else if (|gnt_s) begin
          client_d = gnt_idx_s;
          rr_ptr_d = (gnt_idx_s == IDXW'(CLIENTS - 1)) ? '0 : gnt_idx_s + IDXW'(1);
          if (arp_is_bcast(sel_ip_s, subnet_mask)) begin
            resp_mac_d = ARP_BCAST_MAC;
            resp_err_d = 1'b0;
            state_d    = RESPOND;
          end else begin
            target_d = arp_on_subnet(sel_ip_s, gateway_ip, subnet_mask) ? sel_ip_s : gateway_ip;
            state_d  = QUERY;
          end
        end else begin
          state_d = IDLE;
        end
      end
      QUERY: begin
        if (hit_s) begin
          resp_mac_d = cache_resp_mac;
          resp_err_d = 1'b0;
          state_d    = RESPOND;
        end else if (cache_resp_valid && !tx_valid_q) begin
          // A miss is only taken once the transmit slot is free.
          tx_valid_d = 1'b1;
          tx_tpa_d   = target_q;
          tx_grat_d  = 1'b0;
          retry_d    = RC_LOAD;
          timer_d    = FIRST_C;
          state_d    = WAIT;
        end else begin
          state_d = QUERY;
        end
      end
      WAIT: begin
        if (hit_s) begin
          resp_mac_d = cache_resp_mac;
          resp_err_d = 1'b0;
          state_d    = RESPOND;
        end else if (tx_valid_q && !tx_ready) begin
          timer_d = timer_q;
        end else if (timer_q <= TIMER_WIDTH'(1)) begin
          if (retry_q != '0) begin
            tx_valid_d = 1'b1;
            tx_tpa_d   = target_q;
            tx_grat_d  = 1'b0;
            retry_d    = retry_q - RW'(1);
            timer_d    = (retry_q > RW'(1)) ? RI_C : TO_C;
          end else begin
            timer_d    = '0;
            resp_mac_d = 48'h0000_0000_0000;
            resp_err_d = 1'b1;
            state_d    = RESPOND;
          end
        end else begin
          timer_d = timer_q - TIMER_WIDTH'(1);
        end
      end
      RESPOND: begin
        if (resp_ready[client_q]) begin
          state_d = IDLE;
        end else begin
          state_d = RESPOND;
        end
      end
      ANNOUNCE: begin
        if (tx_valid_q && tx_grat_q) begin
          if (tx_ready) begin
            pend_d  = announce;
            state_d = IDLE;
          end else begin
            state_d = ANNOUNCE;
          end
        end else if (!tx_valid_q) begin
          tx_valid_d = 1'b1;
          tx_tpa_d   = local_ip;
          tx_grat_d  = 1'b1;
        end else begin
          state_d = ANNOUNCE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      client_q   <= '0;
      target_q   <= 32'h0000_0000;
      resp_mac_q <= 48'h0000_0000_0000;
      resp_err_q <= 1'b0;
      tx_valid_q <= 1'b0;
      tx_tpa_q   <= 32'h0000_0000;
      tx_grat_q  <= 1'b0;
      retry_q    <= '0;
      timer_q    <= '0;
      pend_q     <= 1'b0;
      run_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      client_q   <= client_d;
      target_q   <= target_d;
      resp_mac_q <= resp_mac_d;
      resp_err_q <= resp_err_d;
      tx_valid_q <= tx_valid_d;
      tx_tpa_q   <= tx_tpa_d;
      tx_grat_q  <= tx_grat_d;
      retry_q    <= retry_d;
      timer_q    <= timer_d;
      pend_q     <= pend_d;
      run_q      <= 1'b1;
    end
  end

  assign req_ready         = gnt_s;
  assign resp_valid        = (state_q == RESPOND) ? (CLIENTS'(1) << client_q) : '0;
  assign resp_error        = resp_err_q;
  assign resp_mac          = resp_mac_q;
  assign cache_query_valid = (state_q == QUERY) || (state_q == WAIT);
  assign cache_query_ip    = target_q;
  assign tx_valid          = tx_valid_q;
  assign tx_tpa            = tx_tpa_q;
  assign tx_gratuitous     = tx_grat_q;
  assign busy              = (state_q != IDLE);

endmodule

// File: tb/tb_arp_req_engine.sv
// Randomised self-checking bench for arp_req_engine with a lookup-level reference model.
module tb_arp_req_engine;

  localparam int CLIENTS = 4;
  localparam int RC      = 3;
  localparam int RI      = 10;
  localparam int TO      = 20;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [CLIENTS-1:0]    req_valid;
  logic [CLIENTS-1:0]    req_ready;
  logic [CLIENTS*32-1:0] req_ip;
  logic [CLIENTS-1:0]    resp_valid;
  logic [CLIENTS-1:0]    resp_ready;
  logic                  resp_error;
  logic [47:0]           resp_mac;
  logic                  cache_query_valid;
  logic [31:0]           cache_query_ip;
  logic                  cache_resp_valid;
  logic                  cache_resp_error;
  logic [47:0]           cache_resp_mac;
  logic                  tx_valid;
  logic                  tx_ready;
  logic [31:0]           tx_tpa;
  logic                  tx_gratuitous;
  logic [31:0]           local_ip;
  logic [31:0]           gateway_ip;
  logic [31:0]           subnet_mask;
  logic                  announce;
  logic                  busy;

  arp_req_engine #(
    .CLIENTS(CLIENTS), .RETRY_COUNT(RC), .RETRY_INTERVAL(64'd10),
    .TIMEOUT(64'd20), .TIMER_WIDTH(36)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_ip(req_ip),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_error(resp_error), .resp_mac(resp_mac),
    .cache_query_valid(cache_query_valid), .cache_query_ip(cache_query_ip),
    .cache_resp_valid(cache_resp_valid), .cache_resp_error(cache_resp_error),
    .cache_resp_mac(cache_resp_mac), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_tpa(tx_tpa),
    .tx_gratuitous(tx_gratuitous), .local_ip(local_ip), .gateway_ip(gateway_ip),
    .subnet_mask(subnet_mask), .announce(announce), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;
  int cyc   = 0;

  // Cache and transmit-sink behaviour knobs, set per lookup.
  bit          cache_hit = 1'b0;
  logic [47:0] cache_mac = 48'h0;
  int          cache_lat = 1;
  bit          tx_stall  = 1'b0;

  // Observation logs filled by the monitor.
  int          tx_rise_log[$];
  int          tx_acc_log[$];
  logic [31:0] tx_tpa_log[$];
  bit          tx_grat_log[$];
  int          gnt_log[$];
  int          gnt_cyc_log[$];
  int          resp_cli_log[$];
  int          resp_cyc_log[$];
  logic [47:0] resp_mac_log[$];
  bit          resp_err_log[$];
  int          resp_rise_cyc = -1;
  int          hit_cyc = -1;
  int          miss_cyc = -1;
  bit          q_seen = 1'b0;
  logic [31:0] q_ip = 32'h0;
  bit          tx_vprev = 1'b0;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic clear_logs();
    tx_rise_log.delete(); tx_acc_log.delete(); tx_tpa_log.delete(); tx_grat_log.delete();
    gnt_log.delete(); gnt_cyc_log.delete();
    resp_cli_log.delete(); resp_cyc_log.delete(); resp_mac_log.delete(); resp_err_log.delete();
    resp_rise_cyc = -1; hit_cyc = -1; miss_cyc = -1; q_seen = 1'b0;
  endtask

  always @(posedge clk) cyc = cyc + 1;

  // Mid-cycle monitor: records handshakes and first occurrences.
  always @(negedge clk) begin
    if (rst_n) begin
      if (tx_valid && !tx_vprev) tx_rise_log.push_back(cyc);
      if (tx_valid && tx_ready) begin
        tx_acc_log.push_back(cyc); tx_tpa_log.push_back(tx_tpa); tx_grat_log.push_back(tx_gratuitous);
      end
      for (int k = 0; k < CLIENTS; k++) begin
        if (req_valid[k] && req_ready[k]) begin gnt_log.push_back(k); gnt_cyc_log.push_back(cyc); end
        if (resp_valid[k] && resp_ready[k]) begin
          resp_cli_log.push_back(k); resp_cyc_log.push_back(cyc);
          resp_mac_log.push_back(resp_mac); resp_err_log.push_back(resp_error);
        end
      end
      if (resp_valid != '0 && resp_rise_cyc < 0) resp_rise_cyc = cyc;
      if (cache_query_valid && !q_seen) begin q_seen = 1'b1; q_ip = cache_query_ip; end
      if (cache_query_valid && cache_resp_valid) begin
        if (!cache_resp_error && hit_cyc < 0) hit_cyc = cyc;
        if (cache_resp_error && miss_cyc < 0) miss_cyc = cyc;
      end
    end
    tx_vprev = tx_valid;
  end

  // Cache model: answers every cache_lat cycles while a query is held.
  initial begin
    int qcnt;
    qcnt = 0;
    cache_resp_valid = 1'b0; cache_resp_error = 1'b0; cache_resp_mac = 48'h0;
    forever begin
      @(posedge clk); #1;
      if (!cache_query_valid) begin
        cache_resp_valid = 1'b0; qcnt = 0;
      end else begin
        qcnt++;
        if (qcnt >= cache_lat) begin
          cache_resp_valid = 1'b1;
          cache_resp_error = !cache_hit;
          cache_resp_mac   = cache_hit ? cache_mac : {$urandom(), 16'h0};
          qcnt = 0;
        end else begin
          cache_resp_valid = 1'b0;
        end
      end
    end
  end

  // Transmit sink: always ready, or ready about a third of the time when stalling.
  initial begin
    tx_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      tx_ready = tx_stall ? ($urandom_range(0, 2) == 0) : 1'b1;
    end
  end

  // One complete lookup checked against the address rules and retry timing rules.
  task automatic run_lookup(input int cli, input logic [31:0] ip, input bit hit,
                            input logic [47:0] mac, input bit stall);
    int t, bad;
    bit bc;
    logic [31:0] tgt;
    logic [47:0] exp_mac;
    bit exp_err;
    clear_logs();
    cache_hit = hit; cache_mac = mac; tx_stall = stall; cache_lat = $urandom_range(1, 4);
    bc  = ((ip | subnet_mask) == 32'hFFFF_FFFF);
    tgt = (((ip ^ gateway_ip) & subnet_mask) == 32'h0) ? ip : gateway_ip;
    exp_mac = bc ? 48'hFFFF_FFFF_FFFF : (hit ? mac : 48'h0);
    exp_err = !bc && !hit;
    req_ip[32*cli +: 32] = ip;
    req_valid[cli] = 1'b1;
    t = 0;
    while (gnt_log.size() == 0 && t < 200) begin @(posedge clk); #1; t++; end
    req_valid[cli] = 1'b0;
    t = 0;
    while (resp_cli_log.size() == 0 && t < 400) begin @(posedge clk); #1; t++; end
    chk("grant_count", gnt_log.size(), 1);
    chk("resp_count", resp_cli_log.size(), 1);
    if (gnt_log.size() > 0 && resp_cli_log.size() > 0) begin
      chk("grant_client", gnt_log[0], cli);
      chk("resp_client", resp_cli_log[0], cli);
      chk("resp_mac", resp_mac_log[0], exp_mac);
      chk("resp_error", resp_err_log[0], exp_err);
      if (bc) begin
        chk("bcast_no_query", q_seen, 0);
        chk("bcast_latency", resp_rise_cyc - gnt_cyc_log[0], 1);
      end else begin
        chk("query_ip", q_ip, tgt);
        if (hit) begin
          chk("hit_latency", resp_rise_cyc - hit_cyc, 1);
          chk("hit_no_tx", tx_acc_log.size(), 0);
        end else begin
          chk("miss_frames", tx_acc_log.size(), RC);
          bad = 0;
          foreach (tx_tpa_log[i]) if (tx_tpa_log[i] !== tgt || tx_grat_log[i] !== 1'b0) bad++;
          chk("miss_tx_fields", bad, 0);
          if (tx_acc_log.size() == RC && tx_rise_log.size() == RC) begin
            chk("miss_first_tx", tx_rise_log[0], miss_cyc + 1);
            for (int i = 0; i + 1 < RC; i++)
              chk("miss_retry_gap", tx_rise_log[i+1] - tx_acc_log[i], RI);
            chk("miss_timeout", resp_rise_cyc - tx_acc_log[RC-1], TO);
          end
        end
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_req_ready"}, req_ready, 0);
    chk({tag, "_resp_valid"}, resp_valid, 0);
    chk({tag, "_query_valid"}, cache_query_valid, 0);
    chk({tag, "_tx_valid"}, tx_valid, 0);
    chk({tag, "_tx_grat"}, tx_gratuitous, 0);
    chk({tag, "_resp_mac"}, resp_mac, 0);
  endtask

  initial begin
    int t, ngrat, gidx;
    logic [31:0] ip;
    rst_n = 1'b0; req_valid = '1; req_ip = '0; resp_ready = '1; announce = 1'b0;
    local_ip = 32'hC0A8_010A; gateway_ip = 32'hC0A8_0101; subnet_mask = 32'hFFFF_FF00;
    #23;
    check_all_zero("reset");
    req_valid = '0;
    @(posedge clk); #1; rst_n = 1'b1;
    repeat (2) @(posedge clk); #1;

    // Fairness: everyone requests a broadcast address continuously.
    clear_logs();
    for (int k = 0; k < CLIENTS; k++) req_ip[32*k +: 32] = 32'hC0A8_01FF;
    req_valid = '1;
    t = 0;
    while (gnt_log.size() < 5 && t < 100) begin @(posedge clk); #1; t++; end
    resp_ready = '0;
    chk("rr_grant_total", gnt_log.size(), 5);
    for (int i = 0; i < 5; i++) if (i < gnt_log.size()) chk("rr_order", gnt_log[i], i % CLIENTS);
    repeat (20) @(posedge clk); #1;
    chk("stall_no_grant", gnt_log.size(), 5);
    chk("stall_resp_held", resp_valid, 4'b0001);
    req_valid = '0; resp_ready = '1;
    repeat (4) @(posedge clk); #1;

    // Directed lookups.
    run_lookup(2, 32'hC0A8_01FF, 1'b0, 48'h0, 1'b0);
    run_lookup(0, 32'hC0A8_0107, 1'b1, 48'h5A51_5152_5354, 1'b0);
    run_lookup(1, 32'h0A00_0001, 1'b1, 48'h0011_2233_4455, 1'b0);
    run_lookup(3, 32'hC0A8_0133, 1'b0, 48'h0, 1'b0);
    run_lookup(0, 32'hC0A8_0150, 1'b0, 48'h0, 1'b1);

    // Randomised lookups over address class, hit/miss and transmit back-pressure.
    for (int n = 0; n < 20; n++) begin
      subnet_mask = ($urandom_range(0, 1) == 0) ? 32'hFFFF_FF00 : 32'hFFFF_0000;
      case ($urandom_range(0, 2))
        0:       ip = (gateway_ip & subnet_mask) | ~subnet_mask;
        1:       ip = (gateway_ip & subnet_mask) | ($urandom() & ~subnet_mask);
        default: ip = $urandom();
      endcase
      run_lookup($urandom_range(0, CLIENTS-1), ip, $urandom_range(0, 1) == 1,
                 {$urandom(), 16'(($urandom() & 32'h0000_FFFF))}, $urandom_range(0, 1) == 1);
    end
    subnet_mask = 32'hFFFF_FF00;

    // Announce pulsed three times during a miss lookup collapses to one frame after RESPOND.
    fork
      run_lookup(1, 32'hC0A8_0142, 1'b0, 48'h0, 1'b0);
      begin
        for (int p = 0; p < 3; p++) begin
          repeat (4) @(posedge clk); #1; announce = 1'b1;
          @(posedge clk); #1; announce = 1'b0;
        end
      end
    join
    t = 0;
    ngrat = 0;
    while (t < 60) begin @(posedge clk); #1; t++; end
    gidx = -1;
    foreach (tx_grat_log[i]) if (tx_grat_log[i]) begin ngrat++; gidx = i; end
    chk("announce_frames", ngrat, 1);
    if (gidx >= 0 && resp_cyc_log.size() > 0) begin
      chk("announce_tpa", tx_tpa_log[gidx], local_ip);
      chk("announce_after_resp", tx_acc_log[gidx] > resp_cyc_log[0], 1);
    end

    // Reset in the middle of the wait phase abandons the lookup.
    clear_logs();
    cache_hit = 1'b0; tx_stall = 1'b0;
    req_ip[32*2 +: 32] = 32'hC0A8_0177; req_valid[2] = 1'b1;
    t = 0;
    while (gnt_log.size() == 0 && t < 100) begin @(posedge clk); #1; t++; end
    req_valid = '0;
    t = 0;
    while (tx_acc_log.size() == 0 && t < 100) begin @(posedge clk); #1; t++; end
    chk("wait_reached", tx_acc_log.size(), 1);
    repeat (3) @(posedge clk);
    #3; rst_n = 1'b0; req_valid = '1;
    #1;
    check_all_zero("midreset");
    req_valid = '0;
    repeat (3) @(posedge clk); #1;
    clear_logs();
    rst_n = 1'b1;
    repeat (60) @(posedge clk); #1;
    chk("post_reset_tx", tx_acc_log.size(), 0);
    chk("post_reset_resp", resp_cli_log.size(), 0);
    chk("post_reset_busy", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/arp_req_engine.md
ARP_REQ_ENGINE -- requirements
Module: arp_req_engine

Interface
REQ-001 The block SHALL have the parameter CLIENTS, default 4: number of independent lookup client ports, 1..16.
REQ-002 The block SHALL have the parameter RETRY_COUNT, default 4: request frames sent per miss, >=1.
REQ-003 The block SHALL have the parameter RETRY_INTERVAL, default 250000000: cycles between retries.
REQ-004 The block SHALL have the parameter TIMEOUT, default 3750000000: cycles waited after the last request frame.
REQ-005 The block SHALL have the parameter TIMER_WIDTH, default 36: timer width, which SHALL hold both RETRY_INTERVAL and TIMEOUT.
REQ-006 Port clk, in, 1: the single clock; all logic SHALL be clocked on its rising edge.
REQ-007 Port rst_n, in, 1: reset, asynchronous and active-low.
REQ-008 Client request ports: req_valid in CLIENTS, req_ready out CLIENTS, and req_ip in CLIENTS*32 (client i uses bits [32i+31:32i]).
REQ-009 Client response ports: resp_valid out CLIENTS, resp_ready in CLIENTS, resp_error out 1, resp_mac out 48 (resp_error and resp_mac are shared by all clients).
REQ-010 Cache query ports: cache_query_valid out 1, cache_query_ip out 32, cache_resp_valid in 1, cache_resp_error in 1, cache_resp_mac in 48.
REQ-011 Transmit ports: tx_valid out 1, tx_ready in 1, tx_tpa out 32, tx_gratuitous out 1.
REQ-012 Configuration inputs: local_ip, gateway_ip and subnet_mask, each in 32.
REQ-013 Port announce, in, 1: single-cycle request to send a gratuitous ARP frame.
REQ-014 Port busy, out, 1: high in every state except IDLE.

Function
REQ-015 The state machine SHALL have the states IDLE, QUERY, WAIT, RESPOND and ANNOUNCE, and SHALL leave IDLE only from the conditions below.
REQ-016 In IDLE, a pending announce SHALL take priority over clients: go to ANNOUNCE and assert no req_ready.
REQ-017 Otherwise, in IDLE, round-robin arbitration SHALL combinationally assert req_ready on exactly one requesting client, searching from rr_ptr upward; a grant SHALL be registered when req_valid&req_ready.
REQ-018 On a grant, rr_ptr SHALL be set to the granted index+1, wrapping from CLIENTS-1 to 0.
REQ-019 Broadcast classification: if ~(ip|subnet_mask)==0, the next state SHALL be RESPOND with mac=48'hFFFFFFFFFFFF, error=0, and no cache query.
REQ-020 Subnet classification: if ((ip^gateway_ip)&subnet_mask)==0, the target SHALL be ip; otherwise the target SHALL be gateway_ip; in both cases the next state SHALL be QUERY.
REQ-021 In QUERY, cache_query_valid SHALL be held at 1 with cache_query_ip=target until cache_resp_valid.
REQ-022 On a QUERY hit, the block SHALL go to RESPOND with cache_resp_mac.
REQ-023 On a QUERY miss, the block SHALL queue a transmit with tx_tpa=target and tx_gratuitous=0, set retry_cnt=RETRY_COUNT-1, load timer=RETRY_INTERVAL (TIMEOUT if RETRY_COUNT==1), and go to WAIT.
REQ-024 In WAIT, cache_query_valid SHALL be held at 1 and the timer SHALL decrement by 1 per cycle; any hit SHALL go to RESPOND, and a hit SHALL take precedence over a timer expiry in the same cycle.
REQ-025 When the WAIT timer reaches 0 with retry_cnt>0, the block SHALL queue a transmit, decrement retry_cnt, and reload the timer with RETRY_INTERVAL if the old retry_cnt>1, else with TIMEOUT.
REQ-026 When the WAIT timer reaches 0 with retry_cnt==0, the block SHALL go to RESPOND with error=1 and mac=0.
REQ-027 Transmit handshake: tx_valid SHALL be held with tx_tpa and tx_gratuitous stable until tx_ready, and SHALL clear on the cycle after tx_ready.
REQ-028 While tx_valid is still high, the WAIT timer SHALL NOT decrement.
REQ-029 In RESPOND, resp_valid SHALL be asserted only for the granted client, with resp_mac and resp_error stable until resp_ready for that client, after which the block SHALL return to IDLE.
REQ-030 Announce SHALL be latched into a pending flag; repeated pulses while pending SHALL collapse to one frame.
REQ-031 In ANNOUNCE, the block SHALL transmit with tx_tpa=local_ip and tx_gratuitous=1, clear the pending flag on tx_ready, and then return to IDLE.
REQ-032 Latency: a broadcast lookup SHALL assert resp_valid 1 cycle after the grant.
REQ-033 Latency: a hit SHALL assert resp_valid 1 cycle after cache_resp_valid&&!cache_resp_error.
REQ-034 retry_cnt width SHALL be $clog2(RETRY_COUNT+1), and neither the counter nor the timer SHALL ever underflow.

Reset
REQ-035 On rst_n low, the block SHALL go to IDLE, clear rr_ptr, timer, retry_cnt and the announce pending flag, and drive all valid outputs, req_ready, busy and tx_gratuitous to 0 and resp_mac to 0, immediately (asynchronously).
REQ-036 A reset mid-lookup SHALL abandon that lookup with no response and no transmit after release.

Structure
REQ-037 A shared package arp_pkg SHALL hold the state encoding, the ARP oper constants (0x0001, 0x0002, 0x0008, 0x0009) and the broadcast MAC constant.
REQ-038 Round-robin arbitration SHALL be a single sub-module, arp_rr_arbiter, parameterised by CLIENTS.

Verification
REQ-039 Broadcast: subnet_mask=FFFFFF00, client 2 requests 192.168.1.255 -> resp_valid[2] 1 cycle after the grant, resp_mac=FFFFFFFFFFFF, no cache_query_valid.
REQ-040 Hit: gateway_ip=192.168.1.1, client 0 requests 192.168.1.7 with a cache hit returning 5A5151525354 -> cache_query_ip=C0A80107, resp_mac=5A5151525354, error=0; off-subnet 10.0.0.1 -> cache_query_ip=C0A80101.
REQ-041 Full miss: RETRY_COUNT=3, RETRY_INTERVAL=10, TIMEOUT=20 -> exactly 3 tx frames at cycle offsets 0, 10 and 20 (plus tx stall cycles), then resp_error=1 about 20 cycles later.
REQ-042 Fairness: all 4 clients hold req_valid with the broadcast IP -> grants in order 0,1,2,3,0; a stalled resp_ready blocks further grants.
REQ-043 Announce and reset: announce pulsed 3 times during a busy lookup -> exactly one tx with tx_gratuitous=1 and tx_tpa=local_ip after RESPOND; rst_n low in WAIT -> all outputs 0 at once and no later tx.
